// File: rtl/calib_pkg.sv
// Shared state encoding, widths and helpers for the calibration scan sequencer.
package calib_pkg;

    localparam int DAC_CODE_W  = 12;
    localparam int SWITCH_W    = 2;
    localparam int PULSE_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_DONE,
        SETTLE,
        PULSE,
        NEXT,
        DONE
    } scanState_t;

    // A programmed pulse count of zero still runs one SyncClock edge per step.
    function automatic logic [PULSE_CNT_W-1:0] atLeastOne(input logic [PULSE_CNT_W-1:0] n);
        return (n == '0) ? PULSE_CNT_W'(1) : n;
    endfunction

endpackage

// File: rtl/sync_edge_counter.sv
// Registers the free-running SyncClock into Clk, detects its rising edges and
// counts them while enabled, up to a programmed target.
module sync_edge_counter
    import calib_pkg::*;
(
    input  logic                   Clk,
    input  logic                   reset,
    input  logic                   SyncClock,
    input  logic                   Clear,
    input  logic                   Enable,
    input  logic [PULSE_CNT_W-1:0] Target,
    output logic                   CountReached
);

    logic                   syncClk_p0;
    logic                   syncClk_p1;
    logic                   syncRise;
    logic [PULSE_CNT_W-1:0] edgeCount;

    assign syncRise     = syncClk_p0 & ~syncClk_p1;
    assign CountReached = (edgeCount == Target);

    always_ff @(posedge Clk) begin
        if (reset) begin
            syncClk_p0 <= 1'b0;
            syncClk_p1 <= 1'b0;
            edgeCount  <= '0;
        end else begin
            // p0: single capture of SyncClock, p1: previous sample for edge detect
            syncClk_p0 <= SyncClock;
            syncClk_p1 <= syncClk_p0;
            if (Clear) begin
                edgeCount <= '0;
            end else if (Enable && syncRise && !CountReached) begin
                edgeCount <= edgeCount + PULSE_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/calibration_scan_sequencer.sv
// Steps the TLV5618 DAC code from start to stop, settling and pulsing the injection
// switchers at each step. Optional DAC load timeout: define DAC_LOAD_TIMEOUT_EN.
module calibration_scan_sequencer
    import calib_pkg::*;
#(
    parameter int SETTLE_W       = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   Clk,
    input  logic                   reset,
    input  logic                   ScanStart,
    input  logic                   ScanAbort,
    input  logic [DAC_CODE_W-1:0]  DacStartValue,
    input  logic [DAC_CODE_W-1:0]  DacStopValue,
    input  logic [DAC_CODE_W-1:0]  DacStep,
    input  logic [1:0]             DacTarget,
    input  logic [SETTLE_W-1:0]    SettleCycles,
    input  logic [PULSE_CNT_W-1:0] PulsesPerStep,
    input  logic [SWITCH_W-1:0]    ChannelSelect,
    input  logic                   SyncClock,
    input  logic                   DacLoadDone,
    output logic [DAC_CODE_W-1:0]  Dac1Data,
    output logic [DAC_CODE_W-1:0]  Dac2Data,
    output logic [1:0]             LoadDacSelect,
    output logic                   DacLoad,
    output logic [SWITCH_W-1:0]    SwitcherSelect,
    output logic [DAC_CODE_W-1:0]  StepIndex,
    output logic                   StepValid,
    output logic                   ScanBusy,
    output logic                   ScanDone,
    output logic                   ScanError
);

`ifdef DAC_LOAD_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif
    localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);

    scanState_t             state;
    logic [DAC_CODE_W-1:0]  curCode;
    logic [DAC_CODE_W-1:0]  cfgStop;
    logic [DAC_CODE_W-1:0]  cfgStep;
    logic [SETTLE_W-1:0]    cfgSettle;
    logic [SWITCH_W-1:0]    cfgChan;
    logic [PULSE_CNT_W-1:0] cfgPulses;
    logic [SETTLE_W-1:0]    settleCnt;
    logic [TIMEOUT_W-1:0]   timeoutCnt;
    logic [DAC_CODE_W-1:0]  nextCode;
    logic                   lastStep;
    logic                   timeoutHit;
    logic                   pulseClear;
    logic                   pulseEnable;
    logic                   pulseReached;

    // The scan ends when the next code would overflow 12 bits or pass the stop code.
    function automatic logic scanFinished(input logic [DAC_CODE_W-1:0] cur,
                                          input logic [DAC_CODE_W-1:0] step,
                                          input logic [DAC_CODE_W-1:0] stop);
        logic [DAC_CODE_W:0] sum;
        sum = {1'b0, cur} + {1'b0, step};
        return (step == '0) || sum[DAC_CODE_W] || (sum[DAC_CODE_W-1:0] > stop);
    endfunction

    assign nextCode    = curCode + cfgStep;
    assign lastStep    = scanFinished(curCode, cfgStep, cfgStop);
    assign timeoutHit  = TimeoutEn && !DacLoadDone &&
                         (timeoutCnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
    assign pulseClear  = (state != PULSE);
    assign pulseEnable = (state == PULSE);
    assign Dac2Data    = Dac1Data;

    sync_edge_counter uEdgeCounter (
        .Clk          (Clk),
        .reset        (reset),
        .SyncClock    (SyncClock),
        .Clear        (pulseClear),
        .Enable       (pulseEnable),
        .Target       (cfgPulses),
        .CountReached (pulseReached)
    );

    always_ff @(posedge Clk) begin
        if (reset) begin
            state          <= IDLE;
            Dac1Data       <= '0;
            LoadDacSelect  <= '0;
            DacLoad        <= 1'b0;
            SwitcherSelect <= '0;
            StepIndex      <= '0;
            StepValid      <= 1'b0;
            ScanBusy       <= 1'b0;
            ScanDone       <= 1'b0;
            ScanError      <= 1'b0;
        end else begin
            DacLoad   <= 1'b0;
            StepValid <= 1'b0;
            ScanDone  <= 1'b0;
            if (state != IDLE && ScanAbort) begin
                state          <= IDLE;
                SwitcherSelect <= '0;
                ScanBusy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ScanStart && !ScanAbort) begin
                            curCode       <= DacStartValue;
                            cfgStop       <= DacStopValue;
                            cfgStep       <= DacStep;
                            cfgSettle     <= SettleCycles;
                            cfgChan       <= ChannelSelect;
                            cfgPulses     <= atLeastOne(PulsesPerStep);
                            LoadDacSelect <= DacTarget;
                            Dac1Data      <= DacStartValue;
                            DacLoad       <= 1'b1;
                            StepIndex     <= '0;
                            ScanBusy      <= 1'b1;
                            ScanError     <= 1'b0;
                            state         <= LOAD;
                        end
                    end
                    LOAD: begin
                        settleCnt  <= '0;
                        timeoutCnt <= '0;
                        state      <= DacLoadDone ? SETTLE : WAIT_DONE;
                    end
                    WAIT_DONE: begin
                        if (DacLoadDone) begin
                            settleCnt <= '0;
                            state     <= SETTLE;
                        end else if (timeoutHit) begin
                            ScanError      <= 1'b1;
                            SwitcherSelect <= '0;
                            ScanBusy       <= 1'b0;
                            state          <= IDLE;
                        end else begin
                            timeoutCnt <= timeoutCnt + TIMEOUT_W'(1);
                        end
                    end
                    SETTLE: begin
                        if (settleCnt == cfgSettle) begin
                            SwitcherSelect <= cfgChan;
                            state          <= PULSE;
                        end else begin
                            settleCnt <= settleCnt + SETTLE_W'(1);
                        end
                    end
                    PULSE: begin
                        if (pulseReached) begin
                            SwitcherSelect <= '0;
                            StepValid      <= 1'b1;
                            state          <= NEXT;
                        end
                    end
                    NEXT: begin
                        if (lastStep) begin
                            ScanDone <= 1'b1;
                            state    <= DONE;
                        end else begin
                            curCode   <= nextCode;
                            Dac1Data  <= nextCode;
                            DacLoad   <= 1'b1;
                            StepIndex <= StepIndex + DAC_CODE_W'(1);
                            state     <= LOAD;
                        end
                    end
                    DONE: begin
                        ScanBusy <= 1'b0;
                        state    <= IDLE;
                    end
                    default: begin
                        SwitcherSelect <= '0;
                        ScanBusy       <= 1'b0;
                        state          <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calibration_scan_sequencer.sv
// Scoreboard bench for calibration_scan_sequencer: expected DAC loads are queued when a
// scan is started and popped as DacLoad pulses appear; a DAC driver and SyncClock are modelled.
module tb_calibration_scan_sequencer;

    logic        Clk = 1'b0;
    logic        reset;
    logic        ScanStart;
    logic        ScanAbort;
    logic [11:0] DacStartValue;
    logic [11:0] DacStopValue;
    logic [11:0] DacStep;
    logic [1:0]  DacTarget;
    logic [15:0] SettleCycles;
    logic [15:0] PulsesPerStep;
    logic [1:0]  ChannelSelect;
    logic        SyncClock;
    logic        DacLoadDone;
    logic [11:0] Dac1Data;
    logic [11:0] Dac2Data;
    logic [1:0]  LoadDacSelect;
    logic        DacLoad;
    logic [1:0]  SwitcherSelect;
    logic [11:0] StepIndex;
    logic        StepValid;
    logic        ScanBusy;
    logic        ScanDone;
    logic        ScanError;

    calibration_scan_sequencer dut (
        .Clk            (Clk),
        .reset          (reset),
        .ScanStart      (ScanStart),
        .ScanAbort      (ScanAbort),
        .DacStartValue  (DacStartValue),
        .DacStopValue   (DacStopValue),
        .DacStep        (DacStep),
        .DacTarget      (DacTarget),
        .SettleCycles   (SettleCycles),
        .PulsesPerStep  (PulsesPerStep),
        .ChannelSelect  (ChannelSelect),
        .SyncClock      (SyncClock),
        .DacLoadDone    (DacLoadDone),
        .Dac1Data       (Dac1Data),
        .Dac2Data       (Dac2Data),
        .LoadDacSelect  (LoadDacSelect),
        .DacLoad        (DacLoad),
        .SwitcherSelect (SwitcherSelect),
        .StepIndex      (StepIndex),
        .StepValid      (StepValid),
        .ScanBusy       (ScanBusy),
        .ScanDone       (ScanDone),
        .ScanError      (ScanError)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [11:0] code;
        logic [11:0] idx;
    } exp_t;

    exp_t expQ[$];

    int nTests = 0;
    int nFail  = 0;

    // environment state
    int       cyc = 0;
    int       loadCnt = 0;
    int       stepValidCnt = 0;
    int       scanDoneCnt = 0;
    int       edgesInStep = 0;
    int       expEdges = 1;
    int       expSettle = 0;
    logic [1:0] expChan = 2'b00;
    logic [1:0] expTarget = 2'b00;
    bit       dacAckEn = 1'b1;
    int       ackCnt = 0;
    int       doneCyc = 0;
    bit       swOn = 1'b0;
    bit       prevRise = 1'b0;
    int       syncPhase = 0;

    logic [44:0] outVec;
    assign outVec = {Dac1Data, Dac2Data, LoadDacSelect, DacLoad, SwitcherSelect,
                     StepIndex, StepValid, ScanBusy, ScanDone, ScanError};

    // Negedge environment: scoreboard, SyncClock source and DAC driver model.
    initial begin
        SyncClock   = 1'b0;
        DacLoadDone = 1'b0;
        forever begin
            @(negedge Clk);
            cyc++;
            if (DacLoad) begin
                loadCnt++;
                nTests++;
                if (expQ.size() == 0) begin
                    nFail++;
                    $display("FAIL load_unexpected: DacLoad with code %0d idx %0d, none required", Dac1Data, StepIndex);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    if (Dac1Data !== e.code || Dac2Data !== e.code || StepIndex !== e.idx || LoadDacSelect !== expTarget) begin
                        nFail++;
                        $display("FAIL load_code: got dac1 %0d dac2 %0d idx %0d sel %0b, want code %0d idx %0d sel %0b",
                                 Dac1Data, Dac2Data, StepIndex, LoadDacSelect, e.code, e.idx, expTarget);
                    end
                end
            end
            if (SwitcherSelect != 2'b00) begin
                if (!swOn) begin
                    swOn = 1'b1;
                    nTests++;
                    if (SwitcherSelect !== expChan || (cyc - doneCyc) != expSettle + 2) begin
                        nFail++;
                        $display("FAIL pulse_entry: got sel %0b after %0d cycles, want sel %0b after %0d cycles",
                                 SwitcherSelect, cyc - doneCyc, expChan, expSettle + 2);
                    end
                end
                if (prevRise) edgesInStep++;
            end else begin
                swOn = 1'b0;
            end
            if (StepValid) begin
                stepValidCnt++;
                nTests++;
                if (edgesInStep != expEdges) begin
                    nFail++;
                    $display("FAIL step_edges: got %0d SyncClock edges, want %0d", edgesInStep, expEdges);
                end
                edgesInStep = 0;
            end
            if (ScanDone) scanDoneCnt++;
            prevRise = 1'b0;
            syncPhase++;
            if (syncPhase == 3) begin
                syncPhase = 0;
                SyncClock = ~SyncClock;
                prevRise  = SyncClock;
            end
            DacLoadDone = 1'b0;
            if (ackCnt > 0) begin
                ackCnt--;
                if (ackCnt == 0) begin
                    DacLoadDone = 1'b1;
                    doneCyc     = cyc;
                end
            end
            if (DacLoad && dacAckEn) ackCnt = 3;
        end
    end

    initial begin
        #800us;
        $display("FAIL watchdog: simulation time limit reached, want normal finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic start_scan(input int start, input int stop, input int step,
                              input int settle, input int pulses, input logic [1:0] chan,
                              input logic [1:0] target);
        int cur;
        int idx;
        exp_t e;
        DacStartValue = 12'(start);
        DacStopValue  = 12'(stop);
        DacStep       = 12'(step);
        SettleCycles  = 16'(settle);
        PulsesPerStep = 16'(pulses);
        ChannelSelect = chan;
        DacTarget     = target;
        expChan       = chan;
        expTarget     = target;
        expSettle     = settle;
        expEdges      = (pulses == 0) ? 1 : pulses;
        edgesInStep   = 0;
        loadCnt       = 0;
        stepValidCnt  = 0;
        scanDoneCnt   = 0;
        cur = start;
        idx = 0;
        for (int k = 0; k < 4096; k++) begin
            e.code = 12'(cur);
            e.idx  = 12'(idx);
            expQ.push_back(e);
            if (step == 0 || cur + step > 4095 || cur + step > stop) break;
            cur = cur + step;
            idx++;
        end
        ScanStart = 1'b1;
        tick();
        ScanStart = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (ScanDone) begin
                seen = 1'b1;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        nTests++;
        if (outVec !== '0) begin
            nFail++;
            $display("FAIL reset_outputs: got %h, want 0", outVec);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_scan(input string name, input int start, input int stop, input int step,
                             input int settle, input int pulses, input logic [1:0] chan,
                             input int expSteps, input int expLastIdx);
        bit seen;
        start_scan(start, stop, step, settle, pulses, chan, 2'b11);
        wait_done(3000, seen);
        nTests++;
        if (!seen || scanDoneCnt != 1 || ScanBusy !== 1'b0) begin
            nFail++;
            $display("FAIL %s_done: got seen %0d done %0d busy %0b, want 1 1 0", name, seen, scanDoneCnt, ScanBusy);
        end
        nTests++;
        if (loadCnt != expSteps || stepValidCnt != expSteps || expQ.size() != 0 || StepIndex !== 12'(expLastIdx)) begin
            nFail++;
            $display("FAIL %s_steps: got loads %0d valids %0d pending %0d idx %0d, want %0d %0d 0 %0d",
                     name, loadCnt, stepValidCnt, expQ.size(), StepIndex, expSteps, expSteps, expLastIdx);
        end
        expQ.delete();
    endtask

    task automatic test_abort();
        bit seen;
        bit hit;
        start_scan(10, 100, 10, 1, 3, 2'b01, 2'b01);
        hit = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            tick();
            if (StepIndex == 12'd1 && SwitcherSelect != 2'b00) begin
                hit = 1'b1;
                break;
            end
        end
        nTests++;
        if (!hit) begin
            nFail++;
            $display("FAIL abort_reach: got no PULSE in step 1, want one");
        end
        ScanAbort = 1'b1;
        tick();
        ScanAbort = 1'b0;
        nTests++;
        if (SwitcherSelect !== 2'b00 || ScanBusy !== 1'b0 || DacLoad !== 1'b0) begin
            nFail++;
            $display("FAIL abort_outputs: got sel %0b busy %0b load %0b, want 0 0 0", SwitcherSelect, ScanBusy, DacLoad);
        end
        repeat (40) tick();
        nTests++;
        if (scanDoneCnt != 0 || stepValidCnt != 1 || loadCnt != 2) begin
            nFail++;
            $display("FAIL abort_quiet: got done %0d valids %0d loads %0d, want 0 1 2", scanDoneCnt, stepValidCnt, loadCnt);
        end
        expQ.delete();
        start_scan(10, 20, 10, 1, 2, 2'b01, 2'b01);
        wait_done(2000, seen);
        nTests++;
        if (!seen || loadCnt != 2 || expQ.size() != 0) begin
            nFail++;
            $display("FAIL abort_restart: got seen %0d loads %0d pending %0d, want 1 2 0", seen, loadCnt, expQ.size());
        end
        expQ.delete();
    endtask

    task automatic test_start_while_busy();
        bit seen;
        start_scan(100, 130, 10, 2, 2, 2'b01, 2'b10);
        repeat (20) tick();
        DacStartValue = 12'd7;
        DacStopValue  = 12'd4000;
        DacStep       = 12'd1;
        DacTarget     = 2'b01;
        ChannelSelect = 2'b11;
        ScanStart     = 1'b1;
        tick();
        ScanStart     = 1'b0;
        wait_done(3000, seen);
        nTests++;
        if (!seen || loadCnt != 4 || scanDoneCnt != 1 || expQ.size() != 0) begin
            nFail++;
            $display("FAIL busy_start: got seen %0d loads %0d done %0d pending %0d, want 1 4 1 0",
                     seen, loadCnt, scanDoneCnt, expQ.size());
        end
        expQ.delete();
    endtask

    task automatic test_reset_mid();
        dacAckEn = 1'b0;
        start_scan(20, 40, 10, 1, 1, 2'b01, 2'b01);
        repeat (5) tick();
        nTests++;
        if (ScanBusy !== 1'b1) begin
            nFail++;
            $display("FAIL rstmid_busy: got busy %0b, want 1", ScanBusy);
        end
        reset = 1'b1;
        tick();
        nTests++;
        if (outVec !== '0) begin
            nFail++;
            $display("FAIL rstmid_outputs: got %h, want 0", outVec);
        end
        reset = 1'b0;
        repeat (10) tick();
        nTests++;
        if (scanDoneCnt != 0 || ScanBusy !== 1'b0 || loadCnt != 1) begin
            nFail++;
            $display("FAIL rstmid_quiet: got done %0d busy %0b loads %0d, want 0 0 1", scanDoneCnt, ScanBusy, loadCnt);
        end
        expQ.delete();
        dacAckEn = 1'b1;
    endtask

`ifdef DAC_LOAD_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        bit seen;
        dacAckEn = 1'b0;
        start_scan(30, 60, 10, 1, 1, 2'b01, 2'b01);
        n = 1;
        while (ScanBusy && n < 6000) begin
            tick();
            n++;
        end
        nTests++;
        if (ScanError !== 1'b1 || ScanBusy !== 1'b0 || scanDoneCnt != 0 || n < 4096 || n > 4100) begin
            nFail++;
            $display("FAIL timeout_flag: got err %0b busy %0b done %0d after %0d cycles, want 1 0 0 after ~4098",
                     ScanError, ScanBusy, scanDoneCnt, n);
        end
        expQ.delete();
        dacAckEn = 1'b1;
        start_scan(30, 40, 10, 0, 1, 2'b01, 2'b01);
        nTests++;
        if (ScanError !== 1'b0) begin
            nFail++;
            $display("FAIL timeout_clear: got err %0b, want 0", ScanError);
        end
        wait_done(2000, seen);
        nTests++;
        if (!seen || loadCnt != 2) begin
            nFail++;
            $display("FAIL timeout_rescan: got seen %0d loads %0d, want 1 2", seen, loadCnt);
        end
        expQ.delete();
    endtask
`endif

    initial begin
        reset         = 1'b1;
        ScanStart     = 1'b0;
        ScanAbort     = 1'b0;
        DacStartValue = '0;
        DacStopValue  = '0;
        DacStep       = '0;
        DacTarget     = '0;
        SettleCycles  = '0;
        PulsesPerStep = '0;
        ChannelSelect = '0;
        test_reset();
        test_scan("basic", 100, 130, 10, 2, 3, 2'b01, 4, 3);
        test_scan("overflow", 4090, 4095, 10, 1, 1, 2'b11, 1, 0);
        test_scan("zerostep", 50, 100, 0, 1, 2, 2'b10, 1, 0);
        test_scan("reversed", 500, 200, 10, 3, 1, 2'b01, 1, 0);
        test_scan("minimal", 300, 320, 10, 0, 0, 2'b10, 3, 2);
        test_abort();
        test_start_while_busy();
        test_reset_mid();
`ifdef DAC_LOAD_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
